// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, clear-FSM state encoding and lane merge helper for ram_lane_dp
package ram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    localparam int LANE_MAX = 64;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    function automatic logic [LANE_MAX-1:0] lane_merge(
        input logic [LANE_MAX-1:0] old_d,
        input logic [LANE_MAX-1:0] new_d,
        input logic be
    );
        return be ? new_d : old_d;
    endfunction
endpackage

// File: rtl/ram_lane.sv
// ram_lane: one DW-bit lane, 2^AW deep, one write port and one registered read port
module ram_lane #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    // Only the read register is reset; the array itself is cleared by the top's sequencer.
    always_ff @(posedge clk or posedge rst)
        if (rst) rd <= '0;
        else if (re) rd <= mem[ra];
endmodule

// File: rtl/ram_lane_dp.sv
// ram_lane_dp: simple-dual-port RAM with per-lane write enables, 1/2-cycle read latency,
// selectable read-during-write result and a post-reset clear sequencer
module ram_lane_dp
    import ram_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int DN       = 1,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int INIT_CLR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_en,
    input  logic [AW-1:0]      w_addr,
    input  logic [DN-1:0]      w_be,
    input  logic [DN*DW-1:0]   w_data,
    input  logic               r_en,
    input  logic [AW-1:0]      r_addr,
    output logic [DN*DW-1:0]   r_data,
    output logic               r_valid,
    output logic               init_busy
);
    localparam bit NEW_DATA = (RDW_MODE != RDW_OLD);
    localparam state_t RST_ST = (INIT_CLR != 0) ? ST_INIT : ST_RUN;
    state_t state, state_n;
    logic [AW-1:0] clr_addr, clr_addr_n;
    logic rd_go, wr_go, hit, v1;
    logic [DN-1:0] be1;
    logic [DN*DW-1:0] wd1, merged;
    assign init_busy = (state == ST_INIT);
    assign rd_go = r_en & ~init_busy;
    assign wr_go = w_en & ~init_busy;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RST_ST;
            clr_addr <= '0;
        end else begin
            state <= state_n;
            clr_addr <= clr_addr_n;
        end
    always_comb begin
        state_n = state;
        clr_addr_n = clr_addr;
        if (state == ST_INIT) begin
            clr_addr_n = clr_addr + 1'b1;
            if (clr_addr == '1) state_n = ST_RUN;
        end
    end
    // Capture the write that collided with this read so the merged word can be formed after the edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v1 <= 1'b0;
            hit <= 1'b0;
            be1 <= '0;
            wd1 <= '0;
        end else begin
            v1 <= rd_go;
            if (rd_go) begin
                hit <= wr_go & (w_addr == r_addr);
                be1 <= w_be;
                wd1 <= w_data;
            end
        end
    for (genvar i = 0; i < DN; i++) begin : g_lane
        logic [DW-1:0] q;
        ram_lane #(.AW(AW), .DW(DW)) u_lane (
            .clk(clk),
            .rst(rst),
            .we(init_busy | (wr_go & w_be[i])),
            .wa(init_busy ? clr_addr : w_addr),
            .wd(init_busy ? {DW{1'b0}} : w_data[i*DW +: DW]),
            .re(rd_go),
            .ra(r_addr),
            .rd(q)
        );
        assign merged[i*DW +: DW] = DW'(lane_merge(LANE_MAX'(q), LANE_MAX'(wd1[i*DW +: DW]),
                                                   NEW_DATA & hit & be1[i]));
    end
    if (RD_LAT == 1) begin : g_lat1
        assign r_data = merged;
        assign r_valid = v1;
    end else begin : g_lat2
        logic [DN*DW-1:0] d2;
        logic v2;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= merged;
            end
        assign r_data = d2;
        assign r_valid = v2;
    end
endmodule

// File: doc/ram_lane_dp.md
Name: ram_lane_dp

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one read port, DN byte-lane-style lanes of DW bits each, 2^AW words. It extends the behavioural RAM with the following:
- per-lane write enables
- selectable read latency
- defined read-during-write behaviour
- a post-reset clear sequencer

It serves as the general on-chip buffer for datapath blocks, for example weight and activation scratchpads.

Parameters:
AW, 5, address width; depth = 2^AW words
DW, 8, lane width in bits
DN, 1, number of lanes per word; word width = DN*DW
RD_LAT, 1, read latency in clock edges (legal values 1 or 2)
RDW_MODE, 0, same-address read/write collision result: 0 = old data, 1 = new (merged) data
INIT_CLR, 1, 1 = zero the whole array after reset; 0 = no clear

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
w_en  in  1  write request
w_addr  in  AW  write address
w_be  in  DN  per-lane write enable; bit i covers w_data[i*DW +: DW]
w_data  in  DN*DW  write data
r_en  in  1  read request
r_addr  in  AW  read address
r_data  out  DN*DW  read data
r_valid  out  1  single-cycle strobe marking new r_data
init_busy  out  1  high while the clear sequence runs; all requests are ignored

Behaviour:
- Reset (asynchronous, active-high):
  - r_data=0, r_valid=0, read pipeline cleared.
  - Clear counter = 0.
  - State = ST_INIT if INIT_CLR=1, else ST_RUN.
  - init_busy=1 whenever state is ST_INIT (combinational from state).
  - Array contents are not reset directly.
- ST_INIT:
  - Each edge writes 0 to all lanes at clr_addr, then clr_addr increments.
  - On the edge that writes address 2^AW-1, go to ST_RUN.
  - init_busy is therefore high for exactly 2^AW cycles after rst falls.
- ST_INIT request handling:
  - w_en and r_en are dropped, not queued.
  - r_valid stays 0.
- Reset asserted mid-init: restarts the sequence at address 0.
- Write (ST_RUN): at a rising edge with w_en=1, lane i of mem[w_addr] is updated iff w_be[i]=1. w_en=1 with w_be=0 is a legal no-op.
- Read (ST_RUN), request r_en=1 sampled at edge N:
  - RD_LAT=1: r_data is updated and r_valid=1 after edge N.
  - RD_LAT=2: the data passes through one extra output register; r_data is updated and r_valid=1 after edge N+1.
  - Full throughput: one read per cycle, back-to-back.
  - r_valid is high for exactly one cycle per request.
  - r_data holds its last value when no read completes.
- Collision (r_en & w_en & r_addr==w_addr on the same edge):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word. Lanes with w_be set take w_data; the other lanes keep the old data.
- Write-then-read on consecutive edges always returns the new data.
- Addresses: every AW-bit value is valid; no range check, no wrap logic.
- Reset asserted during an in-flight RD_LAT=2 read: the read is discarded and r_valid stays 0.

Decomposition:
- Package ram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1
  - state encoding ST_INIT / ST_RUN
  - function lane_merge(old, new, be)
- Sub-module ram_lane holds one lane: a 2^AW x DW array, one write port with a lane enable, one synchronous read port.
- ram_lane_dp generates DN instances of ram_lane. The top level owns:
  - the clear FSM and counter
  - write muxing (clear vs user)
  - collision bypass
  - the RD_LAT output pipeline and r_valid

Test Plan:
Unless noted: AW=5, DW=8, DN=2, RD_LAT=1, RDW_MODE=0, INIT_CLR=1.
1. rst high for 2 cycles, then low -> init_busy high for exactly 32 cycles. Then read addr 7 -> r_data=0x0000 with r_valid=1 one edge later.
2. w_en=1, addr 3, data 0xABCD, be=11 during init cycle 5 -> after init, read addr 3 returns 0x0000.
3. Write addr 4 0x1234 be=11, then addr 4 0xFF56 be=01, then read addr 4 -> 0x1256.
4. mem[9]=0x1111; same edge: read 9 and write 9 0x2222 be=10 -> r_data=0x1111 (RDW_MODE=0). With RDW_MODE=1 -> 0x2211. Next read of 9 returns 0x2211 in both modes.
5. RD_LAT=2: write addr 31 0x00FD, then back-to-back reads of addresses 28..31 -> r_valid high for 4 consecutive cycles, starting two edges after the first request. The last r_data is 0x00FD.
6. Assert rst at init cycle 10 -> the sequence restarts and init_busy stays high a further 32 cycles. Separately with RD_LAT=2, assert rst one cycle after r_en -> no r_valid pulse and r_data=0.
